// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: one transmitter and one receiver with independent
// state machines that share the clock and a parameter-derived bit period.
module uart_transceiver #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx,
    input  logic       rx,
    output logic       rx_done,
    output logic [7:0] rx_data
);
    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] CNT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF     = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    uart_state_e tx_state_r, tx_state_s;
    logic [15:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_shift_r, tx_shift_s;
    logic        tx_r, tx_s;
    logic        tx_busy_r, tx_busy_s;

    uart_state_e rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s;
    logic [7:0]  rx_data_r, rx_data_s;
    logic        rx_done_r, rx_done_s;
    logic        rx_meta_r, rx_sync_r;

    assign tx      = tx_r;
    assign tx_busy = tx_busy_r;
    assign rx_done = rx_done_r;
    assign rx_data = rx_data_r;

    // Transmitter next state; tx and tx_busy are computed here and registered.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_s       = tx_r;
        tx_busy_s  = tx_busy_r;
        case (tx_state_r)
            IDLE: begin
                tx_s      = 1'b1;
                tx_busy_s = 1'b0;
                tx_cnt_s  = 16'd0;
                if (tx_start) begin
                    tx_shift_s = tx_data;
                    tx_state_s = START;
                    tx_s       = 1'b0;
                    tx_busy_s  = 1'b1;
                end else begin
                    tx_shift_s = tx_shift_r;
                end
            end
            START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s   = 16'd0;
                    tx_bit_s   = 3'd0;
                    tx_state_s = DATA;
                    tx_s       = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s = 16'd0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = STOP;
                        tx_s       = 1'b1;
                    end else begin
                        // Shift ahead so the next bit is always at index 0.
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        tx_s       = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_s   = 16'd0;
                    tx_state_s = IDLE;
                    tx_busy_s  = 1'b0;
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            default: begin
                tx_state_s = IDLE;
                tx_s       = 1'b1;
                tx_busy_s  = 1'b0;
                tx_cnt_s   = 16'd0;
            end
        endcase
    end

    // Transmitter state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_r       <= tx_s;
            tx_busy_r  <= tx_busy_s;
        end
    end

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receiver next state: verify start at half-bit, then sample every full bit.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_data_s  = rx_data_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            IDLE: begin
                rx_cnt_s = 16'd0;
                if (!rx_sync_r) begin
                    rx_state_s = START;
                end else begin
                    rx_state_s = IDLE;
                end
            end
            START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_s = 16'd0;
                    rx_bit_s = 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_s = DATA;
                    end else begin
                        rx_state_s = IDLE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = 16'd0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_s   = 16'd0;
                    rx_state_s = IDLE;
                    // A low stop bit is a framing error: the byte is dropped.
                    if (rx_sync_r) begin
                        rx_data_s = rx_shift_r;
                        rx_done_s = 1'b1;
                    end else begin
                        rx_data_s = rx_data_r;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            default: begin
                rx_state_s = IDLE;
                rx_cnt_s   = 16'd0;
            end
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_done_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_data_r  <= rx_data_s;
            rx_done_r  <= rx_done_s;
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: a frame-level model predicts the
// tx line and received bytes; directed tests cover loopback, timing and errors.
module tb_uart_transceiver;
    localparam int BIT = 434;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx, rx_done;
    logic [7:0] rx_data;
    logic       loopback = 1'b1;
    logic       rx_drv = 1'b1;
    logic       rx_line;

    always #10 clk = ~clk;
    assign rx_line = loopback ? tx : rx_drv;

    uart_transceiver dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx       (tx),
        .rx       (rx_line),
        .rx_done  (rx_done),
        .rx_data  (rx_data)
    );

    // Model: a frame is a 10-bit-period window; bytes expected at rx go in a list.
    logic       m_busy = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] exp_arr [64];
    int         wr_idx = 0;
    int         epoch = 0;
    logic       ext_push = 1'b0;
    logic [7:0] ext_byte = 8'h00;
    logic       exp_tx;

    function automatic logic line_at(input int t, input logic [7:0] b);
        if (t < BIT) return 1'b0;
        else if (t < 9 * BIT) return b[3'((t - BIT) / BIT)];
        else return 1'b1;
    endfunction

    assign exp_tx = m_busy ? line_at(m_t, m_byte) : 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            wr_idx <= 0;
            epoch  <= epoch + 1;
        end else if (m_busy) begin
            m_t <= m_t + 1;
            if (m_t + 1 == 10 * BIT) m_busy <= 1'b0;
        end else if (tx_start) begin
            m_busy <= 1'b1;
            m_t    <= 0;
            m_byte <= tx_data;
            if (loopback) begin
                exp_arr[wr_idx] <= tx_data;
                wr_idx          <= wr_idx + 1;
            end
        end else if (ext_push) begin
            exp_arr[wr_idx] <= ext_byte;
            wr_idx          <= wr_idx + 1;
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         rd_idx = 0;
    int         seen_epoch = 0;
    logic [7:0] m_rx_data = 8'h00;
    logic       prev_done = 1'b0;
    logic       chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx_line", 32'(tx), 32'(exp_tx));
                check("tx_busy", 32'(tx_busy), 32'(m_busy));
                if (epoch != seen_epoch) begin
                    seen_epoch = epoch;
                    rd_idx     = 0;
                    m_rx_data  = 8'h00;
                end
                check("rx_done_width", 32'(prev_done & rx_done), 32'd0);
                if (rx_done) begin
                    if (rd_idx < wr_idx) begin
                        check("rx_data_on_done", 32'(rx_data), 32'(exp_arr[rd_idx]));
                        m_rx_data = exp_arr[rd_idx];
                        rd_idx++;
                    end else begin
                        check("rx_done_spurious", 32'(rx_done), 32'd0);
                    end
                end else begin
                    check("rx_data_hold", 32'(rx_data), 32'(m_rx_data));
                end
                prev_done = rx_done;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 6000 && tx_busy; i++) @(negedge clk);
        check("wait_idle_timeout", 32'(tx_busy), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int stop_len);
        if (stop) begin
            @(negedge clk);
            ext_byte = b;
            ext_push = 1'b1;
            @(negedge clk);
            ext_push = 1'b0;
        end
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_drv = stop;
        repeat (stop_len) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
    endtask

    logic [7:0] lb_bytes [10] = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h01,
                                  8'h80, 8'h33, 8'hCC, 8'hA5, 8'h5A};
    logic [9:0] a5_frame;
    int         busy_cycles;

    initial begin
        fork
            compare_loop();
        join_none

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_rx_done", 32'(rx_done), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        chk_en = 1'b1;

        // A5 frame: start 0, data LSB first 1,0,1,0,0,1,0,1, stop 1
        a5_frame    = 10'b1_1010_0101_0;
        busy_cycles = 0;
        @(negedge clk);
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 0; k < 5000 && tx_busy; k++) begin
            if (k % BIT == BIT / 2)
                check("a5_bit", 32'(tx), 32'(a5_frame[k / BIT]));
            busy_cycles++;
            @(negedge clk);
        end
        check("a5_busy_cycles", 32'(busy_cycles), 32'd4340);
        check("a5_rx_data", 32'(rx_data), 32'hA5);

        for (int i = 0; i < 10; i++) send_byte(lb_bytes[i]);
        repeat (10) @(negedge clk);
        check("loopback_rx_data", 32'(rx_data), 32'h5A);
        check("loopback_count", 32'(rd_idx), 32'd11);

        // Start request and data changes mid-frame must not disturb the frame
        @(negedge clk);
        tx_data  = 8'h96;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (1000) @(negedge clk);
        tx_data  = 8'h3F;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (500) @(negedge clk);
        tx_data = 8'hC3;
        wait_idle();
        repeat (2000) @(negedge clk);
        check("ignore_no_second_frame", 32'(tx_busy), 32'd0);
        check("ignore_rx_data", 32'(rx_data), 32'h96);
        check("ignore_count", 32'(rd_idx), 32'd12);

        loopback = 1'b0;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (100) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1000) @(negedge clk);
        check("glitch_rx_data", 32'(rx_data), 32'h96);
        drive_frame(8'h3C, 1'b1, BIT);
        check("after_glitch_rx_data", 32'(rx_data), 32'h3C);
        drive_frame(8'h7E, 1'b0, 300);
        check("framing_err_rx_data", 32'(rx_data), 32'h3C);
        check("framing_err_count", 32'(rd_idx), 32'(wr_idx));

        loopback = 1'b1;
        @(negedge clk);
        tx_data  = 8'h99;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (1500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_rst_tx", 32'(tx), 32'd1);
        check("midframe_rst_busy", 32'(tx_busy), 32'd0);
        check("midframe_rst_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        repeat (4500) @(negedge clk);
        check("midframe_rst_quiet", 32'(rd_idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
